harmonic_sequencer: RTL and testbench
=====================================

HARMONIC_SEQUENCER -- requirements
Module: harmonic_sequencer

Interface
REQ-001 SHALL have parameter NO_OF_HARMONICS, default 50, number of harmonics dispatched per frame (1..255).
REQ-002 SHALL have parameter SAMPLE_INTERVAL, default 1500, clocks per output sample (72 MHz / 48 kHz).
REQ-003 i_Clock  in  1  single clock; all logic on rising edge.
REQ-004 i_Reset  in  1  synchronous, active-high reset.
REQ-005 i_Sample_Ready  in  1  sine value for o_Harmonic valid.
REQ-006 i_Freq_Too_High  in  1  current harmonic above Nyquist; ends frame early.
REQ-007 i_Adder_Ready  in  2  per-adder idle flag; bit 0 even harmonics, bit 1 odd harmonics.
REQ-008 i_Comb_Interval  in  16  comb spacing C; value below 2 disables muting.
REQ-009 o_Harmonic  out  8  index of harmonic being requested, 0 = fundamental.
REQ-010 o_Next_Sample  out  1  one-cycle pulse; current value consumed, advance position.
REQ-011 o_Adder_Start  out  2  one-cycle start pulse to the selected adder.
REQ-012 o_Adder_Clear  out  1  one-cycle accumulator clear pulse.
REQ-013 o_Mult_Start  out  1  one-cycle pulse; step harmonic scaler.
REQ-014 o_Mult_Restart  out  1  one-cycle pulse; reload harmonic scaler to initial value.
REQ-015 o_Latch_Totals  out  1  one-cycle pulse; capture both adder totals.
REQ-016 o_DAC_Send  out  1  one-cycle pulse; send latched totals to DAC.
REQ-017 o_Overrun  out  1  sticky; a sample tick arrived before the frame finished.

Function
REQ-018 Sample timer SHALL count 0..SAMPLE_INTERVAL-1 free-running, independent of state; tick = count equals SAMPLE_INTERVAL-1.
REQ-019 States SHALL be INIT, DISPATCH, STEP, DRAIN, WAIT_DONE, CAPTURE, CLEAR, WAIT_TICK.
REQ-020 INIT: pulse o_Mult_Restart, o_Harmonic <= 0, load comb counter, -> DISPATCH.
REQ-021 DISPATCH: wait until i_Sample_Ready and i_Adder_Ready[o_Harmonic[0]] are both high; then pulse o_Next_Sample, pulse o_Adder_Start[o_Harmonic[0]] unless muted, and increment o_Harmonic.
REQ-022 On dispatch, SHALL go to DRAIN if o_Harmonic equals NO_OF_HARMONICS-1 or i_Freq_Too_High is high; otherwise go to STEP.
REQ-023 STEP: pulse o_Mult_Start, -> DISPATCH; steady-state throughput is 2 cycles per harmonic.
REQ-024 DRAIN: one cycle, no outputs, lets the adders drop ready, -> WAIT_DONE.
REQ-025 WAIT_DONE: hold until i_Adder_Ready == 2'b11, -> CAPTURE.
REQ-026 CAPTURE: pulse o_Latch_Totals, -> CLEAR.
REQ-027 CLEAR: pulse o_Adder_Clear, -> WAIT_TICK.
REQ-028 WAIT_TICK: on tick, pulse o_DAC_Send, -> INIT; otherwise hold.
REQ-029 A tick in any state other than WAIT_TICK SHALL set o_Overrun; that tick is discarded and the frame completes and waits for the next tick.
REQ-030 All pulse outputs SHALL be registered, high for exactly one cycle, and never asserted outside the states named above.
REQ-031 o_Harmonic SHALL hold between dispatches and never exceed NO_OF_HARMONICS.

Reset
REQ-032 While i_Reset is high: state = INIT, timer = 0, o_Harmonic = 0, all pulse outputs = 0, o_Overrun = 0.
REQ-033 Reset mid-frame SHALL abandon the frame with no o_Latch_Totals or o_DAC_Send; the first cycle after reset executes INIT.
REQ-034 Only i_Reset SHALL clear o_Overrun.

Configuration
REQ-035 Comb muting SHALL be present only when macro COMB_FILTER_EN is defined.
REQ-036 With COMB_FILTER_EN defined: C is sampled in INIT; a harmonic is muted when (index+1) mod C == 0, tracked with a down-counter (no divider). A muted harmonic still pulses o_Next_Sample and advances o_Harmonic, but asserts no o_Adder_Start.
REQ-037 Without COMB_FILTER_EN: i_Comb_Interval is ignored, no harmonic is muted, and no comb counter logic is synthesised.

Verification
REQ-038 Ready inputs held high, NO_OF_HARMONICS=50 -> 50 o_Next_Sample pulses, 25 o_Adder_Start per bit, then o_Latch_Totals, o_Adder_Clear, and o_DAC_Send on the tick; o_Overrun stays 0.
REQ-039 i_Freq_Too_High high at dispatch of harmonic 9 -> exactly 10 dispatches, then DRAIN; next frame restarts at 0 with an o_Mult_Restart pulse.
REQ-040 i_Adder_Ready[1] held low for 20 cycles at harmonic 3 -> no dispatch until it rises; o_Adder_Start[0] not pulsed meanwhile.
REQ-041 SAMPLE_INTERVAL=60, 50 harmonics -> o_Overrun goes high and o_DAC_Send aligns to the next tick after WAIT_TICK is entered.
REQ-042 COMB_FILTER_EN with C=3 -> indices 2,5,8,... produce o_Next_Sample but no o_Adder_Start; with C=0, no harmonic is muted.
REQ-043 i_Reset pulsed during WAIT_DONE -> all outputs 0, o_Overrun cleared, no o_DAC_Send, and INIT executes on the following cycle.

Source files
------------

// File: rtl/harmonic_sequencer.sv
// harmonic_sequencer: per-sample frame sequencer that dispatches harmonics to two adders and hands totals to the DAC.
// Optional comb muting is built only when COMB_FILTER_EN is defined.
module harmonic_sequencer #(
  parameter int NO_OF_HARMONICS = 50,
  parameter int SAMPLE_INTERVAL = 1500
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Sample_Ready,
  input  logic        i_Freq_Too_High,
  input  logic [1:0]  i_Adder_Ready,
  input  logic [15:0] i_Comb_Interval,
  output logic [7:0]  o_Harmonic,
  output logic        o_Next_Sample,
  output logic [1:0]  o_Adder_Start,
  output logic        o_Adder_Clear,
  output logic        o_Mult_Start,
  output logic        o_Mult_Restart,
  output logic        o_Latch_Totals,
  output logic        o_DAC_Send,
  output logic        o_Overrun
);
  localparam int TW = $clog2(SAMPLE_INTERVAL + 1);
  typedef enum logic [2:0] {INIT, DISPATCH, STEP, DRAIN, WAIT_DONE, CAPTURE, CLEAR, WAIT_TICK} state_t;
  state_t state, state_d;
  logic [TW-1:0] timer;
  logic tick, go, last, muted;
  logic [7:0] harm_d;
  logic next_d, clear_d, mult_d, restart_d, latch_d, dac_d;
  logic [1:0] start_d;
  assign tick = timer == TW'(SAMPLE_INTERVAL - 1);
  assign go = i_Sample_Ready && i_Adder_Ready[o_Harmonic[0]];
  assign last = o_Harmonic == 8'(NO_OF_HARMONICS - 1) || i_Freq_Too_High;
`ifdef COMB_FILTER_EN
  // comb_cnt hits zero on every harmonic whose (index+1) is a multiple of C
  logic [15:0] comb_c, comb_cnt;
  logic comb_on;
  assign muted = comb_on && comb_cnt == 16'd0;
  always_ff @(posedge i_Clock)
    if (i_Reset) begin
      comb_c <= 16'd0;
      comb_cnt <= 16'd0;
      comb_on <= 1'b0;
    end else if (state == INIT) begin
      comb_c <= i_Comb_Interval;
      comb_cnt <= i_Comb_Interval - 16'd1;
      comb_on <= i_Comb_Interval > 16'd1;
    end else if (state == DISPATCH && go)
      comb_cnt <= muted ? comb_c - 16'd1 : comb_cnt - 16'd1;
`else
  logic unused_comb;
  assign unused_comb = ^i_Comb_Interval;
  assign muted = 1'b0;
`endif
  always_comb begin
    state_d = state;
    harm_d = o_Harmonic;
    next_d = 1'b0;
    start_d = 2'b00;
    clear_d = 1'b0;
    mult_d = 1'b0;
    restart_d = 1'b0;
    latch_d = 1'b0;
    dac_d = 1'b0;
    case (state)
      INIT: begin
        restart_d = 1'b1;
        harm_d = 8'd0;
        state_d = DISPATCH;
      end
      DISPATCH: if (go) begin
        next_d = 1'b1;
        start_d = muted ? 2'b00 : (o_Harmonic[0] ? 2'b10 : 2'b01);
        harm_d = o_Harmonic + 8'd1;
        state_d = last ? DRAIN : STEP;
      end
      STEP: begin
        mult_d = 1'b1;
        state_d = DISPATCH;
      end
      DRAIN: state_d = WAIT_DONE;
      WAIT_DONE: state_d = i_Adder_Ready == 2'b11 ? CAPTURE : WAIT_DONE;
      CAPTURE: begin
        latch_d = 1'b1;
        state_d = CLEAR;
      end
      CLEAR: begin
        clear_d = 1'b1;
        state_d = WAIT_TICK;
      end
      WAIT_TICK: if (tick) begin
        dac_d = 1'b1;
        state_d = INIT;
      end
      default: state_d = INIT;
    endcase
  end
  always_ff @(posedge i_Clock)
    if (i_Reset) begin
      state <= INIT;
      timer <= '0;
      o_Harmonic <= 8'd0;
      o_Next_Sample <= 1'b0;
      o_Adder_Start <= 2'b00;
      o_Adder_Clear <= 1'b0;
      o_Mult_Start <= 1'b0;
      o_Mult_Restart <= 1'b0;
      o_Latch_Totals <= 1'b0;
      o_DAC_Send <= 1'b0;
      o_Overrun <= 1'b0;
    end else begin
      state <= state_d;
      timer <= tick ? '0 : timer + TW'(1);
      o_Harmonic <= harm_d;
      o_Next_Sample <= next_d;
      o_Adder_Start <= start_d;
      o_Adder_Clear <= clear_d;
      o_Mult_Start <= mult_d;
      o_Mult_Restart <= restart_d;
      o_Latch_Totals <= latch_d;
      o_DAC_Send <= dac_d;
      o_Overrun <= o_Overrun | (tick && state != WAIT_TICK);
    end
endmodule

// File: tb/tb_harmonic_sequencer.sv
// tb_harmonic_sequencer: directed scenario tests; dut uses default timing, dut2 a 60-clock sample interval that overruns.
module tb_harmonic_sequencer;
  logic clk = 1'b0;
  logic rst, sample_ready, freq_high;
  logic [1:0] adder_ready;
  logic [15:0] comb;
  logic [7:0] harm, harm2;
  logic ns, ns2, clr, clr2, ms, ms2, mr, mr2, lt, lt2, dac, dac2, ovr, ovr2;
  logic [1:0] st, st2;
  int checks = 0, fails = 0, cyc = 0;
  int n_ns = 0, n_as0 = 0, n_lt = 0, n_dac = 0;
  int f_ns = 0, f_as0 = 0, f_as1 = 0, f_lt = 0, f_clr = 0;
  logic [1:0] log_st [64];

  always #5 clk = ~clk;

  harmonic_sequencer dut (
    .i_Clock(clk), .i_Reset(rst), .i_Sample_Ready(sample_ready), .i_Freq_Too_High(freq_high),
    .i_Adder_Ready(adder_ready), .i_Comb_Interval(comb), .o_Harmonic(harm), .o_Next_Sample(ns),
    .o_Adder_Start(st), .o_Adder_Clear(clr), .o_Mult_Start(ms), .o_Mult_Restart(mr),
    .o_Latch_Totals(lt), .o_DAC_Send(dac), .o_Overrun(ovr));

  harmonic_sequencer #(.NO_OF_HARMONICS(50), .SAMPLE_INTERVAL(60)) dut2 (
    .i_Clock(clk), .i_Reset(rst), .i_Sample_Ready(sample_ready), .i_Freq_Too_High(freq_high),
    .i_Adder_Ready(adder_ready), .i_Comb_Interval(comb), .o_Harmonic(harm2), .o_Next_Sample(ns2),
    .o_Adder_Start(st2), .o_Adder_Clear(clr2), .o_Mult_Start(ms2), .o_Mult_Restart(mr2),
    .o_Latch_Totals(lt2), .o_DAC_Send(dac2), .o_Overrun(ovr2));

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  always @(negedge clk) begin
    if (mr === 1'b1) begin
      f_ns = 0; f_as0 = 0; f_as1 = 0; f_lt = 0; f_clr = 0;
    end
    if (ns === 1'b1) begin
      if (f_ns < 64) log_st[f_ns] = st;
      f_ns++; n_ns++;
    end
    if (st[0] === 1'b1) begin f_as0++; n_as0++; end
    if (st[1] === 1'b1) f_as1++;
    if (lt === 1'b1) begin f_lt++; n_lt++; end
    if (clr === 1'b1) f_clr++;
    if (dac === 1'b1) n_dac++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_dac(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      seen = dac === 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sample_ready = 1'b1; freq_high = 1'b0; adder_ready = 2'b11; comb = 16'd0;
    repeat (3) step();
    checks++; if (harm !== 8'd0) begin fails++; $display("FAIL reset_harmonic: got %0d expected 0", harm); end
    checks++; if ({ns, st, clr, ms, mr, lt, dac} !== 8'd0) begin fails++; $display("FAIL reset_pulses: got %b expected 00000000", {ns, st, clr, ms, mr, lt, dac}); end
    checks++; if (ovr !== 1'b0 || ovr2 !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b%b expected 00", ovr, ovr2); end
    rst = 1'b0;
    step();
    checks++; if (mr !== 1'b1 || ns !== 1'b0) begin fails++; $display("FAIL init_restart: got mr=%b ns=%b expected mr=1 ns=0", mr, ns); end
    step();
    checks++; if (ns !== 1'b1 || st !== 2'b01 || harm !== 8'd1 || mr !== 1'b0) begin fails++; $display("FAIL first_dispatch: got ns=%b st=%b h=%0d mr=%b expected 1 01 1 0", ns, st, harm, mr); end
    step();
    checks++; if (ms !== 1'b1 || ns !== 1'b0 || harm !== 8'd1) begin fails++; $display("FAIL first_step: got ms=%b ns=%b h=%0d expected 1 0 1", ms, ns, harm); end
  endtask

  task automatic test_overrun();
    int guard = 0;
    while (cyc < 59 && guard < 200) begin step(); guard++; end
    checks++; if (ovr2 !== 1'b0 || cyc != 59) begin fails++; $display("FAIL overrun_before_tick: got ovr=%b cyc=%0d expected 0 59", ovr2, cyc); end
    step();
    checks++; if (ovr2 !== 1'b1) begin fails++; $display("FAIL overrun_set: got %b expected 1", ovr2); end
    guard = 0;
    while (dac2 !== 1'b1 && guard < 200) begin step(); guard++; end
    checks++; if (dac2 !== 1'b1 || cyc != 120) begin fails++; $display("FAIL overrun_dac_align: got dac=%b cyc=%0d expected 1 120", dac2, cyc); end
    checks++; if (ovr !== 1'b0) begin fails++; $display("FAIL no_overrun_main: got %b expected 0", ovr); end
  endtask

  task automatic test_full_frame();
    bit seen;
    wait_dac(3000, seen);
    checks++; if (!seen || cyc != 1500) begin fails++; $display("FAIL frame_dac: got seen=%b cyc=%0d expected 1 1500", seen, cyc); end
    checks++; if (f_ns != 50 || f_as0 != 25 || f_as1 != 25) begin fails++; $display("FAIL frame_counts: got ns=%0d as0=%0d as1=%0d expected 50 25 25", f_ns, f_as0, f_as1); end
    checks++; if (f_lt != 1 || f_clr != 1) begin fails++; $display("FAIL frame_latch_clear: got lt=%0d clr=%0d expected 1 1", f_lt, f_clr); end
    checks++; if (harm !== 8'd50) begin fails++; $display("FAIL frame_harm_max: got %0d expected 50", harm); end
    checks++; if (ovr !== 1'b0 || ovr2 !== 1'b1) begin fails++; $display("FAIL overrun_sticky: got main=%b dut2=%b expected 0 1", ovr, ovr2); end
  endtask

  task automatic test_freq_high();
    int guard = 0;
    do begin
      freq_high = harm == 8'd9;
      step();
      guard++;
    end while (dac !== 1'b1 && guard < 3000);
    freq_high = 1'b0;
    checks++; if (dac !== 1'b1 || cyc != 3000) begin fails++; $display("FAIL freq_dac: got dac=%b cyc=%0d expected 1 3000", dac, cyc); end
    checks++; if (f_ns != 10 || f_as0 != 5 || f_as1 != 5 || harm !== 8'd10) begin fails++; $display("FAIL freq_early_end: got ns=%0d as0=%0d as1=%0d h=%0d expected 10 5 5 10", f_ns, f_as0, f_as1, harm); end
    step();
    checks++; if (mr !== 1'b1 || harm !== 8'd0) begin fails++; $display("FAIL freq_restart: got mr=%b h=%0d expected 1 0", mr, harm); end
  endtask

  task automatic test_ready_stall();
    int guard = 0, a, b;
    bit seen;
    while (harm !== 8'd3 && guard < 100) begin step(); guard++; end
    adder_ready = 2'b01;
    a = n_ns; b = n_as0;
    repeat (20) step();
    checks++; if (n_ns != a || n_as0 != b || harm !== 8'd3) begin fails++; $display("FAIL stall_hold: got ns+%0d as0+%0d h=%0d expected 0 0 3", n_ns - a, n_as0 - b, harm); end
    adder_ready = 2'b11;
    step();
    checks++; if (ns !== 1'b1 || st !== 2'b10 || harm !== 8'd4) begin fails++; $display("FAIL stall_release: got ns=%b st=%b h=%0d expected 1 10 4", ns, st, harm); end
    wait_dac(3000, seen);
    checks++; if (!seen || cyc != 4500 || f_ns != 50 || f_as0 != 25 || f_as1 != 25) begin fails++; $display("FAIL stall_frame: got seen=%b cyc=%0d ns=%0d as0=%0d as1=%0d expected 1 4500 50 25 25", seen, cyc, f_ns, f_as0, f_as1); end
  endtask

  task automatic test_comb();
    bit seen;
    int bad, e0;
    logic [1:0] exp;
    comb = 16'd3;
    wait_dac(3000, seen);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      exp = (k % 2 == 1) ? 2'b10 : 2'b01;
`ifdef COMB_FILTER_EN
      if ((k + 1) % 3 == 0) exp = 2'b00;
      e0 = 17;
`else
      e0 = 25;
`endif
      if (log_st[k] !== exp) bad++;
    end
    checks++; if (!seen || f_ns != 50 || bad != 0) begin fails++; $display("FAIL comb3_pattern: got seen=%b ns=%0d bad=%0d expected 1 50 0", seen, f_ns, bad); end
    checks++; if (f_as0 != e0 || f_as1 != e0) begin fails++; $display("FAIL comb3_counts: got as0=%0d as1=%0d expected %0d %0d", f_as0, f_as1, e0, e0); end
    comb = 16'd0;
    wait_dac(3000, seen);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      exp = (k % 2 == 1) ? 2'b10 : 2'b01;
      if (log_st[k] !== exp) bad++;
    end
    checks++; if (!seen || f_as0 != 25 || f_as1 != 25 || bad != 0) begin fails++; $display("FAIL comb0_nomute: got seen=%b as0=%0d as1=%0d bad=%0d expected 1 25 25 0", seen, f_as0, f_as1, bad); end
  endtask

  task automatic test_reset_wait_done();
    int guard = 0, a, b;
    step();
    while (harm !== 8'd50 && guard < 200) begin step(); guard++; end
    adder_ready = 2'b00;
    a = n_lt; b = n_dac;
    repeat (5) step();
    checks++; if (n_lt != a || harm !== 8'd50) begin fails++; $display("FAIL wait_done_hold: got lt+%0d h=%0d expected 0 50", n_lt - a, harm); end
    rst = 1'b1;
    step();
    checks++; if ({ns, st, clr, ms, mr, lt, dac} !== 8'd0 || harm !== 8'd0) begin fails++; $display("FAIL midreset_outputs: got %b h=%0d expected 00000000 0", {ns, st, clr, ms, mr, lt, dac}, harm); end
    checks++; if (ovr !== 1'b0 || ovr2 !== 1'b0) begin fails++; $display("FAIL midreset_overrun: got %b%b expected 00", ovr, ovr2); end
    rst = 1'b0;
    adder_ready = 2'b11;
    step();
    checks++; if (mr !== 1'b1 || cyc != 1) begin fails++; $display("FAIL midreset_init: got mr=%b cyc=%0d expected 1 1", mr, cyc); end
    repeat (10) step();
    checks++; if (n_lt != a || n_dac != b) begin fails++; $display("FAIL midreset_abandon: got lt+%0d dac+%0d expected 0 0", n_lt - a, n_dac - b); end
  endtask

  initial begin
    test_reset();
    test_overrun();
    test_full_frame();
    test_freq_high();
    test_ready_stall();
    test_comb();
    test_reset_wait_done();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
